// File: rtl/pkc_params_pkg.sv
// Shared parameters, CDT contents, FSM encoding and the xorshift64 step
// for the RLWE noise sampler.
package pkc_params_pkg;

  localparam int unsigned P       = 1049089;
  localparam int unsigned N       = 256;
  localparam int unsigned LOGP    = $clog2(P);
  localparam int unsigned LOGN    = $clog2(N);
  localparam int unsigned CDT_LEN = 16;
  localparam int unsigned CDT_W   = 32;
  localparam logic [63:0] SEED    = 64'h9E37_79B9_7F4A_7C15;

  // One-sided cumulative table of |x|, monotonically increasing, entry 0 in
  // the least-significant slot. Zero's mass is already halved in entry 0.
  localparam logic [CDT_LEN-1:0][CDT_W-1:0] cdt_table = {
    32'hFFFE_C5A1, 32'hFFFE_8DE4, 32'hFFFD_1F2C, 32'hFFF8_DC0B,
    32'hFFEA_5E36, 32'hFFBE_76C9, 32'hFF42_B0D6, 32'hFE0A_9A3B,
    32'hFB3D_07C8, 32'hF566_6F31, 32'hEA64_0E1F, 32'hD78D_4FDF,
    32'hBA56_A1C4, 32'h9133_F0E2, 32'h5CB2_C3A1, 32'h1FEC_56D5
  };

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DRAW = 3'd1,
    SCAN = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic [63:0] xs64_next(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

endpackage

// File: rtl/xorshift64_prng.sv
// xorshift64 state register with load and zero-seed guard.
module xorshift64_prng #(
  parameter logic [63:0] SEED = pkc_params_pkg::SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        step,
  output logic [63:0] state
);
  import pkc_params_pkg::*;

  logic [63:0] x_q;

  // A zero seed would lock xorshift at zero, so it is replaced by SEED.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= SEED;
    end else if (load) begin
      x_q <= (seed == '0) ? SEED : seed;
    end else if (step) begin
      x_q <= xs64_next(x_q);
    end
  end

  assign state = x_q;

endmodule

// File: rtl/gaussian_cdt_sampler.sv
// Constant-time CDT-inversion discrete-Gaussian sampler; emits N
// coefficients mod P per start request over a valid/ready handshake.
module gaussian_cdt_sampler #(
  parameter int unsigned P       = pkc_params_pkg::P,
  parameter int unsigned N       = pkc_params_pkg::N,
  parameter int unsigned LOGP    = $clog2(P),
  parameter int unsigned LOGN    = $clog2(N),
  parameter int unsigned CDT_LEN = pkc_params_pkg::CDT_LEN,
  parameter int unsigned CDT_W   = pkc_params_pkg::CDT_W,
  parameter logic [63:0] SEED    = pkc_params_pkg::SEED,
  parameter logic [CDT_LEN-1:0][CDT_W-1:0] CDT = pkc_params_pkg::cdt_table
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            seed_load,
  input  logic [63:0]     seed_in,
  input  logic            sample_ready,
  output logic [LOGP-1:0] sample_out,
  output logic            sample_valid,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] sample_cnt,
  output logic [2:0]      state
);
  import pkc_params_pkg::*;

  localparam int unsigned MAGW = $clog2(CDT_LEN + 1);
  localparam int unsigned IDXW = (CDT_LEN > 1) ? $clog2(CDT_LEN) : 1;

  state_e            state_q;
  logic [CDT_W-1:0]  u_q;
  logic              sgn_q;
  logic [MAGW-1:0]   acc_q, acc_d;
  logic [IDXW-1:0]   idx_q;
  logic [LOGP-1:0]   sample_out_q;
  logic              valid_q, busy_q, done_q;
  logic [LOGN-1:0]   cnt_q;

  logic [63:0]       prng_x, x_next;
  logic              prng_load, prng_step;
  logic              unused_xbits;

  xorshift64_prng #(
    .SEED (SEED)
  ) u_prng (
    .clk   (clk),
    .reset (reset),
    .load  (prng_load),
    .seed  (seed_in),
    .step  (prng_step),
    .state (prng_x)
  );

  assign prng_load    = seed_load && (state_q == IDLE);
  assign prng_step    = (state_q == DRAW);
  assign x_next       = xs64_next(prng_x);
  assign unused_xbits = ^x_next[62:CDT_W];

  function automatic logic [LOGP-1:0] to_mod_p(input logic [MAGW-1:0] mag,
                                               input logic neg);
    if (neg && (mag != '0)) return LOGP'(P) - LOGP'(mag);
    return LOGP'(mag);
  endfunction

  // Running comparison count including the current table entry.
  always_comb begin
    acc_d = acc_q;
    acc_d = acc_q + MAGW'(u_q >= CDT[idx_q]);
  end

  // Request FSM; the final SCAN cycle maps the completed count so the
  // coefficient is registered on the same edge that enters OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      u_q          <= '0;
      sgn_q        <= 1'b0;
      acc_q        <= '0;
      idx_q        <= '0;
      sample_out_q <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            state_q <= DRAW;
          end
        end
        DRAW: begin
          u_q     <= x_next[CDT_W-1:0];
          sgn_q   <= x_next[63];
          acc_q   <= '0;
          idx_q   <= '0;
          state_q <= SCAN;
        end
        SCAN: begin
          acc_q <= acc_d;
          idx_q <= idx_q + IDXW'(1);
          if (idx_q == IDXW'(CDT_LEN - 1)) begin
            sample_out_q <= to_mod_p(acc_d, sgn_q);
            valid_q      <= 1'b1;
            state_q      <= OUT;
          end
        end
        OUT: begin
          if (sample_ready) begin
            valid_q <= 1'b0;
            if (cnt_q == LOGN'(N - 1)) begin
              cnt_q   <= '0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              cnt_q   <= cnt_q + LOGN'(1);
              state_q <= DRAW;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_cnt   = cnt_q;
  assign state        = state_q;

endmodule

// File: tb/tb_gaussian_cdt_sampler.sv
// Randomized self-checking bench for gaussian_cdt_sampler with a 4-entry CDT.
module tb_gaussian_cdt_sampler;

  localparam int unsigned P       = 1049089;
  localparam int unsigned N       = 256;
  localparam int unsigned LOGP    = 21;
  localparam int unsigned LOGN    = 8;
  localparam int unsigned CDT_LEN = 4;
  localparam logic [63:0] SEED    = 64'h9E37_79B9_7F4A_7C15;
  localparam logic [CDT_LEN-1:0][31:0] DUT_CDT =
    {32'hFFFF_0000, 32'hF000_0000, 32'hC000_0000, 32'h8000_0000};

  logic            clk = 1'b0;
  logic            reset, start, seed_load, sample_ready;
  logic [63:0]     seed_in;
  logic [LOGP-1:0] sample_out;
  logic            sample_valid, busy, done;
  logic [LOGN-1:0] sample_cnt;
  logic [2:0]      state;

  gaussian_cdt_sampler #(
    .CDT_LEN (CDT_LEN),
    .CDT     (DUT_CDT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .seed_load    (seed_load),
    .seed_in      (seed_in),
    .sample_ready (sample_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done),
    .sample_cnt   (sample_cnt),
    .state        (state)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] mx;
  logic [63:0] first_val;
  int unsigned bound [4] = '{32'h8000_0000, 32'hC000_0000, 32'hF000_0000, 32'hFFFF_0000};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: xorshift64 word -> count of bounds at or below u -> signed value mod P.
  function automatic logic [63:0] xs_step(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  function automatic logic [63:0] next_ref();
    int unsigned u, mag;
    mx  = xs_step(mx);
    u   = mx[31:0];
    mag = 0;
    foreach (bound[k]) if (u >= bound[k]) mag++;
    if (mx[63]) return 64'((P - mag) % P);
    return 64'(mag);
  endfunction

  function automatic logic [63:0] undo_shl(input logic [63:0] y, input int s);
    logic [63:0] x;
    x = y;
    for (int k = s; k < 64; k += s) x ^= y << k;
    return x;
  endfunction

  function automatic logic [63:0] undo_shr(input logic [63:0] y, input int s);
    logic [63:0] x;
    x = y;
    for (int k = s; k < 64; k += s) x ^= y >> k;
    return x;
  endfunction

  // Seed whose first xorshift step yields the given word.
  function automatic logic [63:0] seed_for(input logic [63:0] target);
    logic [63:0] t;
    t = undo_shl(target, 17);
    t = undo_shr(t, 7);
    t = undo_shl(t, 13);
    return t;
  endfunction

  task automatic load_seed(input logic [63:0] v);
    seed_in   = v;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    mx = (v == '0) ? SEED : v;
  endtask

  task automatic run_req(input bit rand_ready, input int bp_at, input bit disturb, input int rst_at);
    int          k, wait_c, done_seen, stall;
    logic [63:0] exp;
    logic [LOGP-1:0] held;
    sample_ready = rand_ready ? 1'b0 : 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 1;
    check("busy_after_start", busy, 1);
    while (!sample_valid && k < 40) begin
      tick();
      k++;
    end
    check("first_latency", k, 6);
    if (!sample_valid) return;
    done_seen = 0;
    for (int i = 0; i < N; i++) begin
      exp = next_ref();
      wait_c = 0;
      while (!sample_valid) begin
        if (disturb && i == 3 && wait_c == 2) begin
          check("scan_state", state, 2);
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        tick();
        wait_c++;
        if (done) done_seen++;
        if (wait_c > 40) begin
          check("valid_timeout", 0, 1);
          start = 1'b0;
          return;
        end
      end
      start = 1'b0;
      if (i == rst_at) begin
        sample_ready = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", sample_cnt, 0);
        check("rst_state", state, 0);
        reset = 1'b0;
        mx = SEED;
        return;
      end
      if (disturb && i == 7) begin
        seed_in      = {$urandom, $urandom} | 64'h1;
        seed_load    = 1'b1;
        sample_ready = 1'b0;
        tick();
        seed_load = 1'b0;
        check("seedload_out_valid", sample_valid, 1);
      end
      if (i == bp_at) begin
        held = sample_out;
        sample_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
          tick();
          check("bp_hold", sample_out, held);
          check("bp_valid", sample_valid, 1);
        end
        check("bp_cnt", sample_cnt, 5);
      end
      if (rand_ready) begin
        stall = $urandom_range(0, 3);
        sample_ready = 1'b0;
        for (int c = 0; c < stall; c++) tick();
      end
      if (i == 0) first_val = 64'(sample_out);
      check("sample", sample_out, exp);
      check("cnt", sample_cnt, i);
      sample_ready = 1'b1;
      tick();
      if (done) done_seen++;
      if (i != N - 1) check("valid_drop", sample_valid, 0);
    end
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_cnt", sample_cnt, 0);
    tick();
    if (done) done_seen++;
    check("done_once", done_seen, 1);
    check("back_idle", state, 0);
  endtask

  initial begin
    int any_valid;
    reset = 1'b1; start = 1'b1; seed_load = 1'b0; seed_in = '0; sample_ready = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    check("rst_out", sample_out, 0);
    check("rst_valid0", sample_valid, 0);
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_cnt0", sample_cnt, 0);
    check("rst_state0", state, 0);
    reset = 1'b0; start = 1'b0;
    mx = SEED;
    any_valid = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (sample_valid || busy) any_valid++;
    end
    check("quiet_after_reset", any_valid, 0);

    load_seed(64'h1);
    run_req(1'b0, -1, 1'b0, -1);

    load_seed(seed_for(64'h8000_0000_F800_0000));
    run_req(1'b0, -1, 1'b0, 1);
    check("map_neg3", first_val, 1049086);
    load_seed(seed_for(64'h8000_0000_7FFF_FFFF));
    run_req(1'b0, -1, 1'b0, 1);
    check("map_neg0", first_val, 0);

    load_seed(64'h1);
    run_req(1'b0, 5, 1'b0, -1);

    load_seed(64'h1);
    run_req(1'b0, -1, 1'b1, -1);

    load_seed(64'h0);
    run_req(1'b0, -1, 1'b0, 100);
    run_req(1'b1, -1, 1'b0, 40);

    load_seed({$urandom, $urandom});
    run_req(1'b1, -1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
